// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per owner.
// The last owner gets the lowest priority; an owner holding too long is forced off.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [2:0] win;
    logic [2:0] idx;

    // Descending search starting just below the last owner, wrapping at 0.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q - 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d       = 8'd0;
                grant_id_d    = 3'd0;
                grant_valid_d = 1'b0;
                if (en && found) begin
                    state_d       = StBusy;
                    grant_d       = 8'b1 << win;
                    grant_id_d    = win;
                    grant_valid_d = 1'b1;
                    ptr_d         = win;
                    hold_cnt_d    = 8'd0;
                end
            end
            StBusy: begin
                // Voluntary release wins over a coincident timeout.
                if (!req[grant_id_q]) begin
                    state_d       = StIdle;
                    grant_d       = 8'd0;
                    grant_id_d    = 3'd0;
                    grant_valid_d = 1'b0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d       = StIdle;
                    grant_d       = 8'd0;
                    grant_id_d    = 3'd0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= 3'd0;
            hold_cnt_q    <= 8'd0;
            grant_q       <= 8'd0;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks for rr_arbiter8 with a short hold limit of 4 cycles.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter8 #(
        .MAX_HOLD(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] id, input logic to);
        logic [7:0] exp_grant;
        logic [2:0] exp_id;
        exp_grant = v ? (8'b1 << id) : 8'd0;
        exp_id    = v ? id : 3'd0;
        chk({tag, ".valid"}, 8'(grant_valid), 8'(v));
        chk({tag, ".id"}, 8'(grant_id), 8'(exp_id));
        chk({tag, ".grant"}, grant, exp_grant);
        chk({tag, ".timeout"}, 8'(timeout), 8'(to));
    endtask

    initial begin
        logic [2:0] exp_id;
        logic       ok_onehot;
        logic [7:0] exp_grant;

        rst = 1'b1;
        en  = 1'b0;
        req = 8'd0;
        tick();
        tick();
        chk_out("reset", 1'b0, 3'd0, 1'b0);

        // Reset priority: highest index first.
        rst = 1'b0;
        en  = 1'b1;
        req = 8'b1000_0001;
        tick();
        chk_out("rst_prio", 1'b1, 3'd7, 1'b0);
        req = 8'd0;
        tick();
        chk_out("rst_prio_rel", 1'b0, 3'd0, 1'b0);

        // Rotation with all requesting; each owner drops for one cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_id = 3'(7 - i);
            tick();
            chk_out($sformatf("rot%0d", i), 1'b1, exp_id, 1'b0);
            req = 8'hFF & ~(8'b1 << exp_id);
            tick();
            chk_out($sformatf("rot%0d_gap", i), 1'b0, 3'd0, 1'b0);
            req = 8'hFF;
        end
        req = 8'd0;
        tick();

        // Timeout with a single persistent requester.
        req = 8'b0000_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("hold%0d", i), 1'b1, 3'd2, 1'b0);
        end
        tick();
        chk_out("timeout", 1'b0, 3'd0, 1'b1);
        tick();
        chk_out("regrant", 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk_out("timeout2", 1'b0, 3'd0, 1'b1);
        // Another requester wins over the timed-out one.
        req = 8'b0000_0101;
        tick();
        chk_out("after_to", 1'b1, 3'd0, 1'b0);
        req = 8'd0;
        tick();
        chk_out("after_to_rel", 1'b0, 3'd0, 1'b0);

        // Enable gating.
        en  = 1'b0;
        req = 8'h10;
        tick();
        chk_out("en_off0", 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("en_off1", 1'b0, 3'd0, 1'b0);
        en = 1'b1;
        tick();
        chk_out("en_on", 1'b1, 3'd4, 1'b0);
        en = 1'b0;
        tick();
        chk_out("en_fall0", 1'b1, 3'd4, 1'b0);
        tick();
        chk_out("en_fall1", 1'b1, 3'd4, 1'b0);
        req = 8'd0;
        tick();
        chk_out("en_rel", 1'b0, 3'd0, 1'b0);
        en = 1'b1;

        // Mid-grant reset; afterwards the search must start at 7 again.
        req = 8'h08;
        tick();
        chk_out("pre_rst", 1'b1, 3'd3, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h84;
        tick();
        chk_out("post_rst", 1'b1, 3'd7, 1'b0);
        req = 8'd0;
        tick();
        chk_out("post_rst_rel", 1'b0, 3'd0, 1'b0);

        // Owner drops exactly when the hold limit is reached.
        req = 8'h20;
        tick();
        chk_out("coin0", 1'b1, 3'd5, 1'b0);
        tick();
        tick();
        tick();
        chk_out("coin3", 1'b1, 3'd5, 1'b0);
        req = 8'd0;
        tick();
        chk_out("coin_rel", 1'b0, 3'd0, 1'b0);

        // Random phase: grant/grant_id consistency every cycle.
        for (int i = 0; i < 300; i++) begin
            req = 8'($urandom);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            tick();
            ok_onehot = ($countones(grant) <= 1);
            exp_grant = grant_valid ? (8'b1 << grant_id) : 8'd0;
            chk("rnd.onehot", 8'(ok_onehot), 8'd1);
            chk("rnd.grant", grant, exp_grant);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
